muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_unit_div_iter.sv | 66 ++++++
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide unit: operation encodings and FSM states.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Unsigned restoring radix-2 divider, one quotient bit per cycle.
// quot_o/rem_o carry the values produced by the current iteration, so on the
// cycle done_o is high they are the final quotient and remainder.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o,
    output logic            done_o
);
    localparam int CW = $clog2(XLEN);

    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] dvd_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] rem_q;

    logic [XLEN:0]   rem_sh;
    logic            ge;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quot_nxt;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh   = {rem_q, dvd_q[XLEN-1]};
        ge       = (rem_sh >= {1'b0, dvs_q});
        rem_nxt  = ge ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];
        quot_nxt = {dvd_q[XLEN-2:0], ge};
    end

    assign quot_o = quot_nxt;
    assign rem_o  = rem_nxt;
    assign done_o = busy_q && (cnt_q == '0);

    // Iteration state; the dividend register fills with quotient bits from the right.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
        end else if (kill_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(XLEN - 1);
            dvd_q  <= dividend_i;
            dvs_q  <= divisor_i;
            rem_q  <= '0;
        end else if (busy_q) begin
            dvd_q <= quot_nxt;
            rem_q <= rem_nxt;
            if (cnt_q == '0) busy_q <= 1'b0;
            else             cnt_q  <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with a valid/ready request side and a held result side.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a request; in_ready high (except right after reset)
//   MUL    | multiply latency padding, counts down MUL_STAGES-2 .. 0
//   DIV    | iterative divider running, XLEN cycles
//   DONE   | result held with out_valid until out_ready
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q;
    muldiv_op_t      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [1:0]      cnt_q;
    logic            qneg_q, rneg_q;
    logic [XLEN-1:0] result_q;
    logic            out_valid_q;
    logic            in_ready_q;

    muldiv_op_t      op_in;
    logic            accept;
    logic            signed_div_in, rs1_neg, rs2_neg;
    logic            div_zero, div_ovf, div_start;
    logic [XLEN-1:0] mag_a, mag_b, special_res;
    logic [XLEN-1:0] div_quot, div_rem, quot_fix, rem_fix, div_res;
    logic            div_done;

    // Full 2*XLEN product; each operand is sign- or zero-extended by the op.
    function automatic logic [XLEN-1:0] mul_res(input muldiv_op_t o,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic               sa, sb;
        logic [2*XLEN+1:0]  ax, bx, p;
        sa = ((o == OP_MULH) || (o == OP_MULHSU)) && a[XLEN-1];
        sb = (o == OP_MULH) && b[XLEN-1];
        ax = {{(XLEN+2){sa}}, a};
        bx = {{(XLEN+2){sb}}, b};
        p  = ax * bx;
        return (o == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // Request decode: operand magnitudes and the early-out divide cases.
    always_comb begin
        op_in         = muldiv_op_t'(op);
        accept        = (state_q == S_IDLE) && in_ready_q && in_valid && !flush;
        signed_div_in = op[2] && !op[0];
        rs1_neg       = signed_div_in && rs1[XLEN-1];
        rs2_neg       = signed_div_in && rs2[XLEN-1];
        mag_a         = rs1_neg ? -rs1 : rs1;
        mag_b         = rs2_neg ? -rs2 : rs2;
        div_zero      = (rs2 == '0);
        div_ovf       = signed_div_in && (rs1 == MOST_NEG) && (rs2 == '1);
        if (div_zero) special_res = op[1] ? rs1 : '1;
        else          special_res = op[1] ? '0  : rs1;
        div_start     = accept && op[2] && !div_zero && !div_ovf;
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (div_start),
        .kill_i     (flush),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .quot_o     (div_quot),
        .rem_o      (div_rem),
        .done_o     (div_done)
    );

    // Sign fix-up of the unsigned divider output (truncating division).
    always_comb begin
        quot_fix = qneg_q ? -div_quot : div_quot;
        rem_fix  = rneg_q ? -div_rem  : div_rem;
        div_res  = op_q[1] ? rem_fix : quot_fix;
    end

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MUL;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        op_q       <= op_in;
                        a_q        <= rs1;
                        b_q        <= rs2;
                        qneg_q     <= rs1_neg ^ rs2_neg;
                        rneg_q     <= rs1_neg;
                        if (!op[2]) begin
                            if (MUL_STAGES == 1) begin
                                result_q    <= mul_res(op_in, rs1, rs2);
                                out_valid_q <= 1'b1;
                                state_q     <= S_DONE;
                            end else begin
                                cnt_q   <= 2'(MUL_STAGES - 2);
                                state_q <= S_MUL;
                            end
                        end else if (div_zero || div_ovf) begin
                            result_q    <= special_res;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        result_q    <= mul_res(op_q, a_q, b_q);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DIV: begin
                    if (div_done) begin
                        result_q    <= div_res;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = (state_q != S_IDLE);

endmodule
